// File: rtl/crc_ctrl_pkg.sv
// Shared types and constants for the CRC engine sharing controller.
//   state_t    : controller sequencing states
//   CRC32_POLY : default CRC-32 generator polynomial (33 bits, implicit x^32 included)
//   idx_width  : width of a requester index, never below one bit
package crc_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StResp
  } state_t;

  localparam logic [32:0] CRC32_POLY = 33'h104C11DB7;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/crc_rr_arb.sv
// Combinational round-robin priority search.
//   req : request vector, one bit per requester
//   ptr : index holding highest priority this round
//   gnt : one-hot grant (all zero when nothing requests)
//   idx : binary index of the granted requester
//   any : at least one request present
module crc_rr_arb
  import crc_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    // Walk from ptr upward, wrapping at NREQ-1; first hit wins.
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end
      cand = sum[IW-1:0];
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    gnt = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/crc_share_ctrl.sv
// Shares one CRC engine between NREQ requesters with round-robin arbitration.
// Each job is accepted, launched on the engine, waited on (with a timeout
// watchdog) and answered with the captured CRC plus match/error flags.
//   clk, rst           : clock (rising edge), asynchronous active-low reset
//   req_valid/ready    : per-requester job handshake (ready is one-hot, IDLE only)
//   req_data/poly/exp  : packed per-requester job data, polynomial, expected CRC
//   eng_start          : one-cycle launch pulse to the engine
//   eng_data/poly      : job operands, stable from launch until the wait ends
//   eng_done/crc       : engine completion pulse and its result
//   resp_*             : response handshake, requester id, CRC, ok and error flags
//   busy               : controller is not idle
module crc_share_ctrl
  import crc_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned IW     = idx_width(NREQ),
  localparam int unsigned TW     = $clog2(TIMEOUT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  input  logic [NREQ*(WIDTH+1)-1:0] req_poly,
  input  logic [NREQ*WIDTH-1:0]     req_exp,
  output logic                      eng_start,
  output logic [WIDTH-1:0]          eng_data,
  output logic [WIDTH:0]            eng_poly,
  input  logic                      eng_done,
  input  logic [WIDTH-1:0]          eng_crc,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [IW-1:0]             resp_id,
  output logic [WIDTH-1:0]          resp_crc,
  output logic                      resp_ok,
  output logic                      resp_err,
  output logic                      busy
);

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH:0]   poly_q, poly_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [IW-1:0]    id_q, id_d;
  logic [WIDTH-1:0] crc_q, crc_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;

  logic [NREQ-1:0]  gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;

  crc_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    data_d  = data_q;
    poly_d  = poly_q;
    exp_d   = exp_q;
    id_d    = id_q;
    crc_d   = crc_q;
    ok_d    = ok_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        // A grant implies the matching req_valid bit is high, so it is an accept.
        if (gnt_any) begin
          data_d  = req_data[32'(gnt_idx) * WIDTH +: WIDTH];
          poly_d  = req_poly[32'(gnt_idx) * (WIDTH + 1) +: (WIDTH + 1)];
          exp_d   = req_exp[32'(gnt_idx) * WIDTH +: WIDTH];
          id_d    = gnt_idx;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // Completion takes precedence over an expiring watchdog.
        if (eng_done) begin
          crc_d   = eng_crc;
          ok_d    = (eng_crc == exp_q);
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          crc_d   = '0;
          ok_d    = 1'b0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          ptr_d   = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      timer_q <= '0;
      data_q  <= '0;
      poly_q  <= '0;
      exp_q   <= '0;
      id_q    <= '0;
      crc_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      poly_q  <= poly_d;
      exp_q   <= exp_d;
      id_q    <= id_d;
      crc_q   <= crc_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  // Reset gates req_ready so every output reads zero while rst is low.
  assign req_ready  = (state_q == StIdle && rst) ? gnt : '0;
  assign eng_start  = (state_q == StLaunch);
  assign eng_data   = data_q;
  assign eng_poly   = poly_q;
  assign resp_valid = (state_q == StResp);
  assign resp_id    = id_q;
  assign resp_crc   = crc_q;
  assign resp_ok    = ok_q;
  assign resp_err   = err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_crc_share_ctrl.sv
module tb_crc_share_ctrl;
  import crc_ctrl_pkg::*;

  localparam int W = 32;
  localparam int N = 4;
  localparam int T = 64;

  logic               clk;
  logic               rst;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*W-1:0]     req_data;
  logic [N*(W+1)-1:0] req_poly;
  logic [N*W-1:0]     req_exp;
  logic               eng_start;
  logic [W-1:0]       eng_data;
  logic [W:0]         eng_poly;
  logic               eng_done;
  logic [W-1:0]       eng_crc;
  logic               resp_valid;
  logic               resp_ready;
  logic [1:0]         resp_id;
  logic [W-1:0]       resp_crc;
  logic               resp_ok;
  logic               resp_err;
  logic               busy;

  crc_share_ctrl #(
    .WIDTH   (W),
    .NREQ    (N),
    .TIMEOUT (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_poly   (req_poly),
    .req_exp    (req_exp),
    .eng_start  (eng_start),
    .eng_data   (eng_data),
    .eng_poly   (eng_poly),
    .eng_done   (eng_done),
    .eng_crc    (eng_crc),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_crc   (resp_crc),
    .resp_ok    (resp_ok),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] d_arr[N];
  logic [W:0]   p_arr[N];
  logic [W-1:0] e_arr[N];
  int           ptr_m = 0;
  int           eng_lat = 0;   // 0 = engine never answers
  bit           stray = 1'b0;

  typedef struct {
    logic [N-1:0] valid;
    int           lat;
    int           hold;
    bit           bad;
    int           exp_id;
    bit           exp_ok;
    bit           exp_err;
  } vec_t;

  vec_t tbl[8];

  // Reference CRC: MSB-first shift register, zero initial value, no reflection.
  function automatic logic [W-1:0] crcf(input logic [W-1:0] d, input logic [W:0] p);
    logic [W-1:0] c;
    logic         fb;
    c = '0;
    for (int i = W - 1; i >= 0; i--) begin
      fb = c[W-1] ^ d[i];
      c  = c << 1;
      if (fb) c = c ^ p[W-1:0];
    end
    return c;
  endfunction

  function automatic int rr_model(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W]         = d_arr[i];
      req_poly[i*(W+1) +: (W+1)] = p_arr[i];
      req_exp[i*W +: W]          = e_arr[i];
    end
  endtask

  // Engine model: answers lat cycles after seeing eng_start, using the held operands.
  initial begin
    int cnt;
    cnt      = 0;
    eng_done = 1'b0;
    eng_crc  = '0;
    forever begin
      @(posedge clk);
      #1;
      eng_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          eng_done = 1'b1;
          eng_crc  = crcf(eng_data, eng_poly[W:0]);
        end
      end
      if (stray) begin
        eng_done = 1'b1;
        eng_crc  = $urandom;
        stray    = 1'b0;
      end
      if (eng_start && eng_lat > 0) cnt = eng_lat;
    end
  end

  // One complete job starting from IDLE at a sample point.
  task automatic do_job(input logic [N-1:0] v, input int lat, input int hold,
                        input int exp_id, input bit exp_ok, input bit exp_err);
    logic [W-1:0] exp_crc;
    int           n;
    bit           seen;
    bit           stable;
    exp_crc    = exp_err ? '0 : crcf(d_arr[exp_id], p_arr[exp_id]);
    pack();
    req_valid  = v;
    eng_lat    = lat;
    resp_ready = (hold == 0);
    #1;
    chk("grant", req_ready, N'(1) << exp_id);
    step();
    chk("eng_start", eng_start, 1);
    chk("eng_data", eng_data, d_arr[exp_id]);
    chk("eng_poly", eng_poly, p_arr[exp_id]);
    chk("launch_ready_busy", {req_ready, busy}, 1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < T + lat + 8) begin
      step();
      n++;
      if (n == 1) chk("start_pulse", eng_start, 0);
      seen = resp_valid;
    end
    chk("resp_seen", seen, 1);
    if (seen) begin
      chk("resp_lat", n, ((lat >= 1 && lat <= T) ? lat : T) + 1);
      chk("resp_id", resp_id, exp_id);
      chk("resp_crc", resp_crc, exp_crc);
      chk("resp_ok", resp_ok, exp_ok);
      chk("resp_err", resp_err, exp_err);
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
        step();
        if (!(resp_valid && resp_id == exp_id && resp_crc == exp_crc && resp_ok == exp_ok &&
              resp_err == exp_err && req_ready == '0)) stable = 1'b0;
      end
      if (hold > 0) begin
        chk("resp_hold", stable, 1);
        resp_ready = 1'b1;
      end
      step();
      resp_ready = 1'b0;
      chk("resp_done", {resp_valid, busy}, 0);
    end
    ptr_m = (exp_id + 1) % N;
  endtask

  initial begin
    bit           quiet;
    logic [N-1:0] v;
    int           lat;
    int           id;
    bit           to;
    int           sel;

    rst        = 1'b0;
    req_valid  = '1;
    resp_ready = 1'b0;
    req_data   = '0;
    req_poly   = '0;
    req_exp    = '0;
    for (int i = 0; i < N; i++) begin
      d_arr[i] = 32'hA5000000 + W'(i);
      p_arr[i] = CRC32_POLY;
      e_arr[i] = crcf(d_arr[i], p_arr[i]);
    end
    d_arr[2] = 32'h12345678;
    e_arr[2] = crcf(d_arr[2], p_arr[2]);
    pack();

    // Reset state
    #12;
    chk("reset_ctrl", {req_ready, eng_start, resp_valid, resp_id, resp_ok, resp_err, busy}, 0);
    chk("reset_eng", {eng_data, eng_poly[W-1:0]}, 0);
    chk("reset_crc", resp_crc, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_ptr0", req_ready, 4'b0001);
    req_valid = '0;
    step();

    // Round-robin: all requesting for eight jobs
    for (int j = 0; j < 8; j++) do_job(4'b1111, 2, 0, j % N, 1'b1, 1'b0);

    // Table-driven vectors (pointer is 0 here)
    tbl[0] = '{4'b0100, 34,    0,  1'b0, 2, 1'b1, 1'b0};
    tbl[1] = '{4'b0100, 34,    0,  1'b1, 2, 1'b0, 1'b0};
    tbl[2] = '{4'b1111, 5,     0,  1'b0, 3, 1'b1, 1'b0};
    tbl[3] = '{4'b0110, 0,     0,  1'b0, 1, 1'b0, 1'b1};
    tbl[4] = '{4'b0011, T,     0,  1'b0, 0, 1'b1, 1'b0};
    tbl[5] = '{4'b0011, T + 1, 0,  1'b0, 1, 1'b0, 1'b1};
    tbl[6] = '{4'b1001, 1,     10, 1'b0, 3, 1'b1, 1'b0};
    tbl[7] = '{4'b1000, 3,     0,  1'b1, 3, 1'b0, 1'b0};
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++)
        e_arr[i] = tbl[t].bad ? 32'hDEADBEEF : crcf(d_arr[i], p_arr[i]);
      do_job(tbl[t].valid, tbl[t].lat, tbl[t].hold, tbl[t].exp_id, tbl[t].exp_ok,
             tbl[t].exp_err);
    end

    // Stray eng_done while idle
    req_valid = '0;
    stray     = 1'b1;
    quiet     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (resp_valid || busy) quiet = 1'b0;
    end
    chk("stray_done_ignored", quiet, 1);

    // Randomized jobs against the reference model
    for (int r = 0; r < 24; r++) begin
      v = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        d_arr[i] = $urandom;
        p_arr[i] = {1'b1, W'($urandom)};
        e_arr[i] = ($urandom_range(0, 1) == 1) ? W'($urandom) : crcf(d_arr[i], p_arr[i]);
      end
      sel = $urandom_range(0, 9);
      lat = (sel == 0) ? 0 : (sel == 1) ? T : (sel == 2) ? T + 1 : $urandom_range(1, 40);
      id  = rr_model(ptr_m, v);
      to  = (lat == 0) || (lat > T);
      do_job(v, lat, $urandom_range(0, 3), id, !to && (crcf(d_arr[id], p_arr[id]) == e_arr[id]),
             to);
    end

    // Reset in the middle of WAIT
    for (int i = 0; i < N; i++) e_arr[i] = crcf(d_arr[i], p_arr[i]);
    do_job(4'b0001, 2, 0, 0, 1'b1, 1'b0);
    pack();
    req_valid = '1;
    eng_lat   = 0;
    step();
    for (int k = 0; k < 10; k++) step();
    chk("pre_reset_busy", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_ctrl", {req_ready, eng_start, resp_valid, resp_id, resp_ok, resp_err, busy}, 0);
    chk("midrst_eng", {eng_data, eng_poly[W-1:0]}, 0);
    chk("midrst_crc", resp_crc, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ptr0", req_ready, 4'b0001);
    req_valid = '0;
    step();
    ptr_m = 0;
    do_job(4'b1111, 3, 0, 0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation watchdog expired");
  end

endmodule

// File: doc/crc_share_ctrl.md
Name: crc_share_ctrl

Overview:
- Shares one CRC engine (WIDTH-bit data, WIDTH+1-bit polynomial, start/done handshake) between NREQ requesters using round-robin arbitration.
- Sequences each job through the engine: accept, launch, wait, respond.
- Compares the engine result against a requester-supplied expected value and flags match/mismatch.
- A timeout watchdog aborts hung jobs with an error response.
- Sits between CRC generator/checker clients and the single shared CRC datapath.

Parameters:
- WIDTH, 32, data and CRC width; polynomial is WIDTH+1 bits.
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum cycles in WAIT before abort (>= 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester job request.
- req_ready  out  NREQ  one-hot accept; job transfers when req_valid[i] and req_ready[i] are both 1.
- req_data  in  NREQ*WIDTH  packed job data; requester i uses slice i.
- req_poly  in  NREQ*(WIDTH+1)  packed generator polynomials.
- req_exp  in  NREQ*WIDTH  packed expected CRC values.
- eng_start  out  1  one-cycle engine launch pulse.
- eng_data  out  WIDTH  engine data, held stable from LAUNCH until leaving WAIT.
- eng_poly  out  WIDTH+1  engine polynomial, held the same way as eng_data.
- eng_done  in  1  one-cycle engine completion pulse.
- eng_crc  in  WIDTH  engine result, valid while eng_done is 1.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumer ready.
- resp_id  out  $clog2(NREQ)  requester index of the job.
- resp_crc  out  WIDTH  captured CRC; 0 on timeout.
- resp_ok  out  1  1 if resp_crc equals the latched expected value and no error.
- resp_err  out  1  1 if the job timed out.
- busy  out  1  1 whenever state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr pointer=0, timer=0, job registers=0, every output=0.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - Grant = first i with req_valid[i], searching from pointer upward with wrap at NREQ-1 -> 0.
  - req_ready is asserted combinationally for the granted index only, and only in IDLE.
  - On accept: latch data, poly, exp and id; next state LAUNCH.
  - No valid requests: stay in IDLE.
- LAUNCH: eng_start=1 for exactly one cycle; timer cleared; next state WAIT.
- WAIT:
  - eng_done=1: capture eng_crc; resp_ok=(eng_crc==exp); resp_err=0; next state RESP.
  - Otherwise timer increments. Timer==TIMEOUT-1 without eng_done: resp_crc=0, resp_ok=0, resp_err=1; next state RESP.
  - eng_done and timeout in the same cycle: eng_done wins, no error.
- RESP:
  - resp_valid=1; resp_id, resp_crc, resp_ok and resp_err held stable until resp_valid and resp_ready are both 1.
  - On handshake: pointer=(id+1) mod NREQ; next state IDLE.
  - resp_ready asserted early (already 1 when RESP is entered) completes the handshake that cycle.
- eng_done outside WAIT is ignored; it produces no response and no state change.
- A requester dropping req_valid before accept is legal; no job starts for it.
- Latency: accept -> eng_start is 1 cycle; eng_done -> resp_valid is 1 cycle. Minimum job = 4 cycles plus engine latency.
- Fairness: a continuously requesting client waits at most NREQ-1 jobs.
- Throughput: one job in flight; no back-to-back accept while busy.

Decomposition:
- Package crc_ctrl_pkg holds:
  - state_t enum (IDLE, LAUNCH, WAIT, RESP).
  - Default CRC-32 polynomial constant CRC32_POLY = 33'h104C11DB7.
  - Function for index width.
- Sub-module crc_rr_arb: combinational round-robin priority search.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any.

Test Plan:
- Single job, engine model latency 34: req_valid[2]=1, data=32'h12345678, poly=CRC32_POLY, exp=correct CRC -> eng_start 1 cycle after accept; resp_id=2, resp_ok=1, resp_err=0; resp_valid 1 cycle after eng_done.
- Mismatch: same job with exp=32'hDEADBEEF -> resp_ok=0, resp_err=0, resp_crc equals the engine value.
- Round-robin: all four req_valid held at 1 for 8 jobs -> resp_id sequence 0,1,2,3,0,1,2,3.
- Timeout: engine never returns eng_done, TIMEOUT=64 -> resp_err=1 and resp_crc=0 exactly 64 cycles after LAUNCH; the next job proceeds normally.
- Backpressure and corner cases:
  - resp_ready=0 for 10 cycles -> response held stable, req_ready stays 0.
  - Stray eng_done while IDLE -> no response.
  - eng_done on the timeout cycle -> resp_err=0.
- Reset mid-WAIT: rst=0 asynchronously -> all outputs 0 immediately; after release, state=IDLE and pointer=0 (requester 0 wins when all request).
